seq_nonrestoring_divider: RTL and testbench

Multi-cycle, parametrised non-restoring integer divider for the datapath DIV instruction. It computes one quotient bit per clock and supports signed and unsigned modes. It flags divide-by-zero and uses a start/busy/done handshake with the control unit. It replaces the single-cycle combinational divider, which was unclocked, 32-bit only and unsigned only.

---
 rtl/div_pkg.sv | 30 +++
 rtl/div_nr_step.sv | 36 +++
 rtl/seq_nonrestoring_divider.sv | 200 ++++++++++++++++++++
 tb/tb_seq_nonrestoring_divider.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//
// Contents:
//   div_state_e     - controller states (IDLE, ITER, FIX)
//   DIV_MIN_WIDTH   - smallest supported operand width
//   DIV_MAX_WIDTH   - widest operand the all-ones constant can cover
//   DIV0_QUOTIENT   - all-ones pattern returned as quotient on divide-by-zero
//   div_cnt_width() - width of the iteration counter for a given WIDTH
package div_pkg;

  // IDLE waits for start, ITER produces one quotient bit per clock,
  // FIX restores the remainder, applies signs and publishes the results.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_MIN_WIDTH = 4;
  localparam int DIV_MAX_WIDTH = 256;

  // Wider than any supported WIDTH; the top slices off what it needs.
  localparam logic [DIV_MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

  // The counter runs WIDTH-1 down to 0, so it needs clog2(WIDTH) bits.
  function automatic int div_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring division step (purely combinational).
//
// Ports:
//   i_a [WIDTH:0]   - partial remainder (two's complement, sign in bit WIDTH)
//   i_q [WIDTH-1:0] - quotient / remaining dividend bits
//   i_m [WIDTH:0]   - zero-extended divisor magnitude
//   o_a [WIDTH:0]   - partial remainder after shift and add/subtract
//   o_q [WIDTH-1:0] - quotient after shift with the new bit in o_q[0]
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_a_shift;

  // Shift {A,Q} left by one, then subtract M when the old A was
  // non-negative or add it back when the old A was negative. The decision
  // uses the sign before the shift: the shifted value may overflow the
  // WIDTH+1 bit range, but the add/subtract result always fits again.
  // The new quotient bit is set when the result is non-negative.
  always_comb begin
    w_a_shift = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
    if (i_a[WIDTH]) begin
      o_a = w_a_shift + i_m;
    end else begin
      o_a = w_a_shift - i_m;
    end
    o_q = {i_q[WIDTH-2:0], ~o_a[WIDTH]};
  end

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Multi-cycle non-restoring integer divider, one quotient bit per clock,
// signed or unsigned, with divide-by-zero detection.
//
// Ports:
//   clock        - rising-edge system clock
//   clear_n      - asynchronous active-low reset
//   start        - request, sampled only in IDLE
//   signed_mode  - 1 = two's-complement operands, sampled with start
//   dividend     - sampled with start
//   divisor      - sampled with start
//   busy         - high while a division is in progress
//   done         - one-cycle pulse when results are valid
//   quotient     - registered result, held until the next done
//   remainder    - registered result, held until the next done
//   div_by_zero  - registered with the results, held until the next done
//
// Latency is WIDTH+1 cycles from the start edge (1 cycle for a zero
// divisor). Signed division truncates toward zero; the remainder takes the
// dividend's sign. MIN / -1 wraps to MIN with no flag.
module seq_nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                CW        = div_cnt_width(WIDTH);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0]  QUOT_DIV0 = DIV0_QUOTIENT[WIDTH-1:0];

  // Elaboration-time guard on the supported width range.
  if ((WIDTH < DIV_MIN_WIDTH) || (WIDTH > DIV_MAX_WIDTH)) begin : g_width_check
    $error("seq_nonrestoring_divider: WIDTH out of supported range");
  end

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_dvd_neg;
  logic             r_dvs_neg;
  logic             r_div0;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_divisor_zero;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot_res;
  logic [WIDTH-1:0] w_rem_res;

  // Single shared step datapath, fed from the working registers.
  div_nr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_m (r_m),
    .o_a (w_a_next),
    .o_q (w_q_next)
  );

  // Operand conditioning at load time. Sign flags only exist in signed
  // mode, so unsigned operands always pass through untouched. Negating
  // MIN gives MIN again, which is the correct magnitude read as unsigned.
  always_comb begin
    w_divisor_zero = (divisor == '0);
    w_dvd_neg      = signed_mode & dividend[WIDTH-1];
    w_dvs_neg      = signed_mode & divisor[WIDTH-1];
    w_dvd_mag      = w_dvd_neg ? -dividend : dividend;
    w_dvs_mag      = w_dvs_neg ? -divisor  : divisor;
  end

  // Final correction. A negative partial remainder gets M added back; the
  // sum always fits in WIDTH bits, so the low bits are computed directly.
  // Signs are then reapplied: quotient negative when the operand signs
  // differ, remainder follows the dividend.
  always_comb begin
    w_rem_mag  = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m[WIDTH-1:0]) : r_a[WIDTH-1:0];
    w_quot_res = (r_dvd_neg ^ r_dvs_neg) ? -r_q : r_q;
    w_rem_res  = r_dvd_neg ? -w_rem_mag : w_rem_mag;
  end

  // Controller state register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A zero divisor skips the iterations and goes
  // straight to FIX so the flagged result appears one cycle after start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = w_divisor_zero ? FIX : ITER;
        end
      end
      ITER: begin
        if (r_cnt == '0) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Working registers and result registers. On a zero divisor the raw
  // dividend is parked in Q so FIX can return it as the remainder without
  // a separate holding register. Results only move on the FIX edge, which
  // is also the only edge that raises done.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_cnt         <= '0;
      r_a           <= '0;
      r_m           <= '0;
      r_q           <= '0;
      r_dvd_neg     <= 1'b0;
      r_dvs_neg     <= 1'b0;
      r_div0        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt     <= CNT_LAST;
            r_a       <= '0;
            r_m       <= {1'b0, w_dvs_mag};
            r_q       <= w_divisor_zero ? dividend : w_dvd_mag;
            r_dvd_neg <= w_dvd_neg;
            r_dvs_neg <= w_dvs_neg;
            r_div0    <= w_divisor_zero;
          end
        end
        ITER: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CNT_ONE;
        end
        FIX: begin
          r_done        <= 1'b1;
          r_div_by_zero <= r_div0;
          if (r_div0) begin
            r_quotient  <= QUOT_DIV0;
            r_remainder <= r_q;
          end else begin
            r_quotient  <= w_quot_res;
            r_remainder <= w_rem_res;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  // busy is a decode of the state register, so it rises on the start edge
  // and falls on the same edge that raises done.
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Bench for seq_nonrestoring_divider: a 32-bit and an 8-bit instance share
// one clock. Expected results come from plain integer arithmetic; a queue of
// expected completions per instance carries the start and done cycles.
module tb_seq_nonrestoring_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          acc;
    int          dn;
  } exp_t;

  logic        clock;
  logic        clearN;
  logic        start32, start8, signed32, signed8;
  logic [31:0] dvd32, dvs32;
  logic [7:0]  dvd8, dvs8;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] q32, r32;
  logic [7:0]  q8, r8;

  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;
  bit   checkEn = 0;
  exp_t expQ0[$];
  exp_t expQ1[$];
  logic [31:0] lastQ [2];
  logic [31:0] lastR [2];
  logic        lastDz [2];

  seq_nonrestoring_divider #(.WIDTH(32)) dut32 (
    .clock(clock), .clear_n(clearN), .start(start32), .signed_mode(signed32),
    .dividend(dvd32), .divisor(dvs32), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_by_zero(dz32)
  );

  seq_nonrestoring_divider #(.WIDTH(8)) dut8 (
    .clock(clock), .clear_n(clearN), .start(start8), .signed_mode(signed8),
    .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges; inputs are driven and outputs checked on falling edges.
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: truncating integer division of w-bit operands.
  function automatic exp_t model(input int w, input bit sgn, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [31:0] mask, ua, ub;
    longint sa, sb, qq, rr;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ua = a & mask;
    ub = b & mask;
    e = '{default: 0};
    if (ub == 32'd0) begin
      e.q = mask; e.r = ua; e.dz = 1'b1;
    end else if (sgn) begin
      sa = {32'd0, ua};
      sb = {32'd0, ub};
      if (ua[w-1]) sa = sa - (longint'(1) << w);
      if (ub[w-1]) sb = sb - (longint'(1) << w);
      qq = sa / sb;
      rr = sa % sb;
      e.q = 32'(qq) & mask;
      e.r = 32'(rr) & mask;
    end else begin
      e.q = ua / ub;
      e.r = ua % ub;
    end
    return e;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic pin(input string name, input int w, input bit s, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                     input logic edz);
    exp_t e;
    e = model(w, s, a, b);
    check1({name, " q"}, e.q, eq);
    check1({name, " r"}, e.r, er);
    check1({name, " dz"}, {31'd0, e.dz}, {31'd0, edz});
  endtask

  // Compares one instance against the head of its expectation queue.
  task automatic checkOutput(input int id);
    exp_t h;
    bit have, busyExp, doneExp;
    string tag;
    logic [31:0] aq, ar;
    logic ab, ad, az;
    have = 0;
    h = '{default: 0};
    if (id == 0) begin
      tag = "d32"; aq = q32; ar = r32; ab = busy32; ad = done32; az = dz32;
      if (expQ0.size() > 0) begin have = 1; h = expQ0[0]; end
    end else begin
      tag = "d8"; aq = {24'd0, q8}; ar = {24'd0, r8}; ab = busy8; ad = done8; az = dz8;
      if (expQ1.size() > 0) begin have = 1; h = expQ1[0]; end
    end
    busyExp = have && (cyc >= h.acc) && (cyc < h.dn);
    doneExp = have && (cyc == h.dn);
    if (doneExp) begin
      lastQ[id] = h.q; lastR[id] = h.r; lastDz[id] = h.dz;
      if (id == 0) h = expQ0.pop_front();
      else         h = expQ1.pop_front();
    end
    check1({tag, " busy"}, {31'd0, ab}, {31'd0, busyExp});
    check1({tag, " done"}, {31'd0, ad}, {31'd0, doneExp});
    check1({tag, " quotient"}, aq, lastQ[id]);
    check1({tag, " remainder"}, ar, lastR[id]);
    check1({tag, " div_by_zero"}, {31'd0, az}, {31'd0, lastDz[id]});
  endtask

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput(0);
      checkOutput(1);
    end
  end

  // Issues one request from a falling edge; start is sampled at the next
  // rising edge, after which the operands are scrambled.
  task automatic applyStimulus(input int id, input bit sgn, input logic [31:0] a,
                               input logic [31:0] b);
    exp_t e;
    int w;
    w = (id == 0) ? 32 : 8;
    e = model(w, sgn, a, b);
    e.acc = cyc + 1;
    e.dn  = e.acc + (e.dz ? 1 : w + 1);
    if (id == 0) begin
      start32 = 1'b1; signed32 = sgn; dvd32 = a; dvs32 = b; expQ0.push_back(e);
    end else begin
      start8 = 1'b1; signed8 = sgn; dvd8 = a[7:0]; dvs8 = b[7:0]; expQ1.push_back(e);
    end
    @(negedge clock);
    start32 = 1'b0; start8 = 1'b0;
    signed32 = 1'($urandom); signed8 = 1'($urandom);
    dvd32 = $urandom; dvs32 = $urandom; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
  endtask

  task automatic waitDone(input int id);
    int n;
    n = 0;
    while (((id == 0) ? done32 : done8) !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL wait_done id%0d: got no done in 200 cycles, expected done", id);
    end
  endtask

  task automatic doReset();
    #2 clearN = 1'b0;
    expQ0.delete();
    expQ1.delete();
    for (int i = 0; i < 2; i++) begin lastQ[i] = '0; lastR[i] = '0; lastDz[i] = 1'b0; end
    #1;
    check1("rst d32 busy", {31'd0, busy32}, 32'd0);
    check1("rst d32 done", {31'd0, done32}, 32'd0);
    check1("rst d32 quotient", q32, 32'd0);
    check1("rst d32 remainder", r32, 32'd0);
    check1("rst d8 busy", {31'd0, busy8}, 32'd0);
    check1("rst d8 quotient", {24'd0, q8}, 32'd0);
    @(negedge clock);
    clearN = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b;
    bit s;
    clearN = 1'b0;
    start32 = 1'b0; start8 = 1'b0; signed32 = 1'b0; signed8 = 1'b0;
    dvd32 = '0; dvs32 = '0; dvd8 = '0; dvs8 = '0;
    for (int i = 0; i < 2; i++) begin lastQ[i] = '0; lastR[i] = '0; lastDz[i] = 1'b0; end

    pin("model 100/7",    32, 0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    pin("model -100/7",   32, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    pin("model 100/-7",   32, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
    pin("model MIN/-1",   32, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    pin("model 55/0",     32, 1, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1);
    pin("model w8 200/13", 8, 0, 32'd200, 32'd13, 32'd15, 32'd5, 1'b0);

    repeat (2) @(negedge clock);
    checkEn = 1;
    @(negedge clock);
    clearN = 1'b1;
    @(negedge clock);

    applyStimulus(0, 0, 32'd100, 32'd7);                 waitDone(0);
    applyStimulus(0, 1, 32'hFFFF_FF9C, 32'd7);           waitDone(0);
    applyStimulus(0, 1, 32'd100, 32'hFFFF_FFF9);         waitDone(0);
    applyStimulus(0, 0, 32'hFFFF_FFFF, 32'd1);           waitDone(0);
    applyStimulus(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);   waitDone(0);
    applyStimulus(0, 0, 32'd55, 32'd0);                  waitDone(0);
    applyStimulus(0, 1, 32'd55, 32'd0);                  waitDone(0);
    applyStimulus(0, 0, 32'd1000, 32'd10);               waitDone(0);

    // A second start mid-division must be ignored.
    applyStimulus(0, 0, 32'd500, 32'd9);
    repeat (8) @(negedge clock);
    start32 = 1'b1; signed32 = 1'b1; dvd32 = 32'd777; dvs32 = 32'd0;
    @(negedge clock);
    start32 = 1'b0;
    waitDone(0);
    applyStimulus(0, 0, 32'd9999, 32'd3);                waitDone(0);

    applyStimulus(1, 0, 32'd200, 32'd13);                waitDone(1);

    // Reset in the middle of a division on both instances.
    applyStimulus(0, 0, 32'd12345, 32'd77);
    applyStimulus(1, 0, 32'd250, 32'd3);
    repeat (12) @(negedge clock);
    doReset();
    applyStimulus(0, 0, 32'd1000, 32'd10);               waitDone(0);
    applyStimulus(1, 0, 32'd200, 32'd13);                waitDone(1);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      applyStimulus(0, s, a, b);
      waitDone(0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 7);
        2: begin a = 32'h80; b = 32'hFF; end
        3: b = 32'hFF;
        default: ;
      endcase
      applyStimulus(1, s, a, b);
      waitDone(1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1000000;
    nChecks++;
    nFails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
